// File: rtl/ad_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ad_frame_fifo
// Description : Frame buffer between the AD7606 sample controller and the MCU
//               parallel-bus decoder. Stores whole 8 x 16-bit conversion
//               frames and serves the head frame one byte per read request,
//               so the 8-bit MCU never sees channels from different frames.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_valid,
    input  logic [127:0]  ch_data,
    input  logic          rd_req,
    input  logic          clear,
    output logic [7:0]    rd_byte,
    output logic          rd_byte_vld,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          overflow
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  C_LAST  = 4'd15;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_byte_idx;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_overflow;
    logic [7:0]    r_rd_byte;
    logic          r_rd_vld;

    logic          w_push;
    logic          w_drop;
    logic          w_rd_acc;
    logic          w_pop;
    logic [127:0]  w_head;
    logic [7:0]    w_byte;
    logic [CW-1:0] w_count_nxt;

    // Full/empty are judged on the registered (pre-cycle) state; clear discards
    // any write or read request presented in the same cycle.
    assign w_push      = frame_valid && !r_full && !clear;
    assign w_drop      = frame_valid &&  r_full && !clear;
    assign w_rd_acc    = rd_req && !r_empty && !clear;
    assign w_pop       = w_rd_acc && (r_byte_idx == C_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    // Channel k occupies bits [16k+15:16k], so byte n is simply bits [8n+7:8n].
    assign w_byte      = w_head[{r_byte_idx, 3'b000} +: 8];
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Frame storage; contents need no reset because count/pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ch_data;
        end
    end

    // Pointer, byte index, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_byte_idx <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_byte_idx <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == C_DEPTH);
        end
    end

    // Read data path: byte is held between accepted requests, valid pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_byte <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_byte <= w_byte;
            end
        end
    end

    assign rd_byte     = r_rd_byte;
    assign rd_byte_vld = r_rd_vld;
    assign fifo_count  = r_count;
    assign fifo_empty  = r_empty;
    assign fifo_full   = r_full;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_frame_fifo
// Description : Self-checking bench for ad_frame_fifo. Directed scenarios and
//               a randomized run, compared cycle by cycle with a queue-based
//               model of the frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_frame_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          frame_valid;
    logic [127:0]  ch_data;
    logic          rd_req;
    logic          clear;
    logic [7:0]    rd_byte;
    logic          rd_byte_vld;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;

    ad_frame_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .ch_data     (ch_data),
        .rd_req      (rd_req),
        .clear       (clear),
        .rd_byte     (rd_byte),
        .rd_byte_vld (rd_byte_vld),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of whole frames plus a read cursor.
    logic [127:0] m_q[$];
    int           m_idx;
    bit           m_ovf;
    logic [7:0]   m_byte;
    bit           m_vld;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fifo_count",  128'(fifo_count),  128'(m_q.size()));
        chk("fifo_empty",  128'(fifo_empty),  128'(m_q.size() == 0));
        chk("fifo_full",   128'(fifo_full),   128'(m_q.size() == DEPTH));
        chk("overflow",    128'(overflow),    128'(m_ovf));
        chk("rd_byte_vld", 128'(rd_byte_vld), 128'(m_vld));
        chk("rd_byte",     128'(rd_byte),     128'(m_byte));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idx  = 0;
        m_ovf  = 0;
        m_byte = 8'h00;
        m_vld  = 0;
    endtask

    // Apply one cycle of inputs (called #1 after a rising edge), advance the
    // model by the buffer's rules, and check outputs #1 after the next edge.
    task automatic cycle(input bit fv, input logic [127:0] d, input bit rq, input bit clr);
        logic [127:0] head;
        bit           was_full;
        bit           do_pop;
        frame_valid = fv;
        ch_data     = d;
        rd_req      = rq;
        clear       = clr;
        m_vld       = 0;
        if (clr) begin
            m_q.delete();
            m_idx = 0;
            m_ovf = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            do_pop   = 0;
            if (rq && m_q.size() > 0) begin
                head   = m_q[0];
                m_byte = head[m_idx*8 +: 8];
                m_vld  = 1;
                if (m_idx == 15) begin
                    m_idx  = 0;
                    do_pop = 1;
                end else begin
                    m_idx++;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (fv) begin
                if (was_full) m_ovf = 1;
                else          m_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        rd_req      = 1'b0;
        clear       = 1'b0;
        check_all();
    endtask

    function automatic logic [127:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Read until the model is empty; bounded so a stuck DUT cannot hang us.
    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 16*DEPTH + 4) begin
            cycle(0, '0, 1, 0);
            guard++;
        end
        chk("drain_bound", 128'(m_q.size()), 128'(0));
    endtask

    logic [127:0] f_known;
    logic [127:0] f_tmp;

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        ch_data     = '0;
        rd_req      = 1'b0;
        clear       = 1'b0;
        model_reset();

        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_rd_byte_const", 128'(rd_byte), 128'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle(0, '0, 0, 0);

        // 2: one known frame, read all 16 bytes
        f_known = {16'h8899, 16'h789A, 16'h6789, 16'h5678,
                   16'h4567, 16'h3456, 16'h2345, 16'h1234};
        cycle(1, f_known, 0, 0);
        cycle(0, '0, 1, 0);
        chk("t2_first_byte", 128'(rd_byte), 128'(8'h34));
        cycle(0, '0, 1, 0);
        chk("t2_second_byte", 128'(rd_byte), 128'(8'h12));
        for (int i = 2; i < 16; i++) cycle(0, '0, 1, 0);
        chk("t2_last_byte", 128'(rd_byte), 128'(8'h88));
        chk("t2_empty_after", 128'(fifo_empty), 128'(1));

        // 3: five frames into a four-deep buffer, then read everything
        for (int i = 0; i < 5; i++) cycle(1, rnd_frame(), 0, 0);
        chk("t3_count", 128'(fifo_count), 128'(4));
        chk("t3_full", 128'(fifo_full), 128'(1));
        chk("t3_ovf", 128'(overflow), 128'(1));
        drain();

        // 4: full, 16th read coincides with a new frame -> frame dropped
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, rnd_frame(), 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, '0, 1, 0);
        cycle(1, rnd_frame(), 1, 0);
        chk("t4_count", 128'(fifo_count), 128'(3));
        chk("t4_ovf", 128'(overflow), 128'(1));
        drain();

        // 5: reads while empty are ignored; next frame starts at byte 0
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        f_tmp = rnd_frame();
        cycle(1, f_tmp, 1, 0);
        chk("t5_push_same_cycle_vld", 128'(rd_byte_vld), 128'(0));
        cycle(0, '0, 1, 0);
        chk("t5_byte0", 128'(rd_byte), 128'(f_tmp[7:0]));
        drain();

        // 6: clear in the middle of a two-frame buffer
        cycle(1, rnd_frame(), 0, 0);
        cycle(1, rnd_frame(), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
        cycle(1, rnd_frame(), 1, 1);
        chk("t6_count", 128'(fifo_count), 128'(0));
        chk("t6_ovf", 128'(overflow), 128'(0));
        f_tmp = rnd_frame();
        cycle(1, f_tmp, 0, 0);
        cycle(0, '0, 1, 0);
        chk("t6_byte0", 128'(rd_byte), 128'(f_tmp[7:0]));
        drain();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 10) < 3, rnd_frame(),
                  ($urandom % 10) < 7, ($urandom % 200) == 0);
        end

        // Asynchronous reset in the middle of a frame read
        cycle(1, rnd_frame(), 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f_tmp = rnd_frame();
        cycle(1, f_tmp, 0, 0);
        cycle(0, '0, 1, 0);
        chk("rst_mid_byte0", 128'(rd_byte), 128'(f_tmp[7:0]));
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 10) < 4, rnd_frame(), ($urandom % 10) < 6, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
